// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter sharing the single-ported boot ROM between NB_MASTERS read ports.
// Writes and out-of-window addresses are granted but answered with an error, never reaching the ROM.
module boot_rom_arbiter #(
    parameter int NB_MASTERS     = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int ROM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_MASTERS-1:0]            req_i,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0] add_i,
    input  logic [NB_MASTERS-1:0]            wen_i,
    output logic [NB_MASTERS-1:0]            gnt_o,
    output logic [NB_MASTERS-1:0]            r_valid_o,
    output logic [NB_MASTERS*DATA_WIDTH-1:0] r_rdata_o,
    output logic [NB_MASTERS-1:0]            r_opc_o,
    output logic                             rom_csn_o,
    output logic [ROM_ADDR_WIDTH-3:0]        rom_add_o,
    input  logic [DATA_WIDTH-1:0]            rom_rdata_i
);

    localparam int IDW = $clog2(NB_MASTERS);
    localparam int HIW = ADDR_WIDTH - ROM_ADDR_WIDTH;

    logic [IDW-1:0]            rr_q;
    logic                      resp_valid_q;
    logic [IDW-1:0]            resp_id_q;
    logic                      resp_err_q;

    logic                      any_gnt;
    logic [IDW-1:0]            win;
    logic [HIW-1:0]            win_hi;
    logic [ROM_ADDR_WIDTH-3:0] win_word;
    logic                      win_wen;
    logic                      win_err;
    logic [NB_MASTERS-1:0]     unused_byte_lsb;

    // Scan from the pointer upward with wrap; first asserted request wins.
    always_comb begin
        int idx;
        idx      = 0;
        any_gnt  = 1'b0;
        win      = '0;
        win_hi   = '0;
        win_word = '0;
        win_wen  = 1'b1;
        gnt_o    = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NB_MASTERS) idx = idx - NB_MASTERS;
            if (!any_gnt && req_i[idx]) begin
                any_gnt  = 1'b1;
                win      = idx[IDW-1:0];
                win_hi   = add_i[idx*ADDR_WIDTH+ROM_ADDR_WIDTH +: HIW];
                win_word = add_i[idx*ADDR_WIDTH+2 +: ROM_ADDR_WIDTH-2];
                win_wen  = wen_i[idx];
            end
        end
        for (int k = 0; k < NB_MASTERS; k++) begin
            gnt_o[k] = any_gnt && (win == IDW'(k));
        end
    end

    always_comb begin
        for (int k = 0; k < NB_MASTERS; k++) begin
            unused_byte_lsb[k] = ^add_i[k*ADDR_WIDTH +: 2];
        end
    end

    assign win_err   = !win_wen || (win_hi != '0);
    assign rom_csn_o = !(any_gnt && !win_err && !rst_i);
    assign rom_add_o = any_gnt ? win_word : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else if (any_gnt) begin
            rr_q         <= (win == IDW'(NB_MASTERS - 1)) ? '0 : win + 1'b1;
            resp_valid_q <= 1'b1;
            resp_id_q    <= win;
            resp_err_q   <= win_err;
        end else begin
            resp_valid_q <= 1'b0;
        end
    end

    // ROM data arrives this cycle for last cycle's grant; steer it to that master only.
    always_comb begin
        r_valid_o = '0;
        r_opc_o   = '0;
        r_rdata_o = '0;
        for (int k = 0; k < NB_MASTERS; k++) begin
            if (resp_id_q == IDW'(k)) begin
                r_valid_o[k] = resp_valid_q;
                r_opc_o[k]   = resp_valid_q && resp_err_q;
                if (resp_valid_q && !resp_err_q) begin
                    r_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rom_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Self-checking bench for boot_rom_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of round-robin arbitration.
module tb_boot_rom_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_i = '0;
    logic [63:0] add_i = '0;
    logic [1:0]  wen_i = 2'b11;
    logic [1:0]  gnt_o;
    logic [1:0]  r_valid_o;
    logic [63:0] r_rdata_o;
    logic [1:0]  r_opc_o;
    logic        rom_csn_o;
    logic [10:0] rom_add_o;
    logic [31:0] rom_rdata_i = '0;

    logic [31:0] rom_mem [0:2047];

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int          m_rr = 0;
    bit          m_pv = 0;
    int          m_pid = 0;
    bit          m_perr = 0;
    logic [31:0] m_paddr = '0;

    // per-cycle observed / expected values
    logic [1:0]  obs_gnt, exp_gnt, obs_rv, exp_rv, obs_opc, exp_opc;
    logic        obs_csn, exp_csn;
    logic [10:0] obs_radd, exp_radd;
    logic [63:0] obs_rd, exp_rd;

    boot_rom_arbiter #(
        .NB_MASTERS(2), .ADDR_WIDTH(32), .ROM_ADDR_WIDTH(13), .DATA_WIDTH(32)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
        .rom_csn_o(rom_csn_o), .rom_add_o(rom_add_o), .rom_rdata_i(rom_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // boot ROM macro: synchronous read on a csn-low cycle
    always @(posedge clk_i) begin
        if (!rom_csn_o) rom_rdata_i <= rom_mem[rom_add_o];
    end

    // One bus cycle: capture last cycle's response, drive new inputs, capture the
    // combinational decision, then advance the model across the clock edge.
    task automatic cycle(input logic rs, input logic [1:0] r, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [1:0] w);
        int          wn;
        bit          e;
        logic [31:0] a;
        @(negedge clk_i);
        obs_rv  = r_valid_o;
        obs_opc = r_opc_o;
        obs_rd  = r_rdata_o;
        exp_rv  = '0;
        exp_opc = '0;
        exp_rd  = '0;
        if (m_pv) begin
            exp_rv[m_pid]  = 1'b1;
            exp_opc[m_pid] = m_perr;
            exp_rd[m_pid*32 +: 32] = m_perr ? 32'h0 : rom_mem[m_paddr[12:2]];
        end
        rst_i = rs;
        req_i = r;
        add_i = {a1, a0};
        wen_i = w;
        #1;
        obs_gnt  = gnt_o;
        obs_csn  = rom_csn_o;
        obs_radd = rom_add_o;
        wn = -1;
        for (int i = 0; i < 2; i++) begin
            if (wn < 0 && r[(m_rr + i) % 2]) wn = (m_rr + i) % 2;
        end
        a = (wn == 1) ? a1 : a0;
        e = (wn >= 0) && (!w[wn] || (a >= 32'h2000));
        exp_gnt  = '0;
        exp_radd = '0;
        if (wn >= 0) begin
            exp_gnt[wn] = 1'b1;
            exp_radd = a[12:2];
        end
        exp_csn = !(wn >= 0 && !e && !rs);
        @(posedge clk_i);
        if (rs) begin
            m_rr = 0;
            m_pv = 0;
        end else if (wn >= 0) begin
            m_rr    = (wn + 1) % 2;
            m_pv    = 1;
            m_pid   = wn;
            m_perr  = e;
            m_paddr = a;
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 2'b11);
        cycle(1'b1, 2'b00, 32'h0, 32'h0, 2'b11);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
        vectors++;
        if (obs_rv !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid got=%b want=00", obs_rv); end
        vectors++;
        if (obs_opc !== 2'b00) begin miscompares++; $display("FAIL reset_opc got=%b want=00", obs_opc); end
        vectors++;
        if (obs_rd !== 64'h0) begin miscompares++; $display("FAIL reset_rdata got=%h want=0", obs_rd); end
        vectors++;
        if (obs_gnt !== 2'b00 || obs_csn !== 1'b1 || obs_radd !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_idle gnt=%b csn=%b add=%h want 00/1/000", obs_gnt, obs_csn, obs_radd);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] aw [4];
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                aw[k] = {19'h0, 11'($urandom_range(0, 2047)), 2'b00};
                cycle(1'b0, 2'b11, aw[k], aw[k], 2'b11);
            end else begin
                cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
            end
            if (k < 4) begin
                vectors++;
                if (obs_gnt !== want[k]) begin miscompares++; $display("FAIL contention_gnt%0d got=%b want=%b", k, obs_gnt, want[k]); end
            end
            if (k > 0) begin
                vectors++;
                if (obs_rv !== want[k-1]) begin miscompares++; $display("FAIL contention_rvalid%0d got=%b want=%b", k, obs_rv, want[k-1]); end
                vectors++;
                if (obs_rd[(k-1)%2*32 +: 32] !== rom_mem[aw[k-1][12:2]]) begin
                    miscompares++;
                    $display("FAIL contention_rdata%0d got=%h want=%h", k, obs_rd[(k-1)%2*32 +: 32], rom_mem[aw[k-1][12:2]]);
                end
            end
        end
    endtask

    task automatic test_single_read();
        cycle(1'b0, 2'b01, 32'h0000_0004, 32'h0, 2'b11);
        vectors++;
        if (obs_gnt !== 2'b01 || obs_csn !== 1'b0 || obs_radd !== 11'd1) begin
            miscompares++;
            $display("FAIL single_req gnt=%b csn=%b add=%h want 01/0/001", obs_gnt, obs_csn, obs_radd);
        end
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
        vectors++;
        if (obs_rv !== 2'b01 || obs_opc !== 2'b00 || obs_rd[31:0] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL single_resp rv=%b opc=%b rdata=%h want 01/00/deadbeef", obs_rv, obs_opc, obs_rd[31:0]);
        end
    endtask

    task automatic test_write_reject();
        cycle(1'b0, 2'b10, 32'h0, 32'h0000_0010, 2'b01);
        vectors++;
        if (obs_gnt !== 2'b10 || obs_csn !== 1'b1) begin
            miscompares++;
            $display("FAIL write_req gnt=%b csn=%b want 10/1", obs_gnt, obs_csn);
        end
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
        vectors++;
        if (obs_rv !== 2'b10 || obs_opc !== 2'b10 || obs_rd[63:32] !== 32'h0) begin
            miscompares++;
            $display("FAIL write_resp rv=%b opc=%b rdata=%h want 10/10/0", obs_rv, obs_opc, obs_rd[63:32]);
        end
    endtask

    task automatic test_out_of_window();
        cycle(1'b0, 2'b01, 32'h0000_2000, 32'h0, 2'b11);
        vectors++;
        if (obs_gnt !== 2'b01 || obs_csn !== 1'b1) begin
            miscompares++;
            $display("FAIL oow_req gnt=%b csn=%b want 01/1", obs_gnt, obs_csn);
        end
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
        vectors++;
        if (obs_rv !== 2'b01 || obs_opc !== 2'b01 || obs_rd[31:0] !== 32'h0) begin
            miscompares++;
            $display("FAIL oow_resp rv=%b opc=%b rdata=%h want 01/01/0", obs_rv, obs_opc, obs_rd[31:0]);
        end
    endtask

    task automatic test_reset_midop();
        cycle(1'b0, 2'b01, 32'h8, 32'h0, 2'b11);
        cycle(1'b1, 2'b01, 32'hC, 32'h0, 2'b11);
        vectors++;
        if (obs_csn !== 1'b1) begin miscompares++; $display("FAIL midrst_csn got=%b want=1", obs_csn); end
        cycle(1'b0, 2'b11, 32'h10, 32'h14, 2'b11);
        vectors++;
        if (obs_rv !== 2'b00) begin miscompares++; $display("FAIL midrst_rvalid got=%b want=00", obs_rv); end
        vectors++;
        if (obs_gnt !== 2'b01) begin miscompares++; $display("FAIL midrst_gnt got=%b want=01", obs_gnt); end
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
    endtask

    task automatic test_streaming();
        int base;
        base = $urandom_range(0, 2039);
        for (int k = 0; k < 9; k++) begin
            if (k < 8) cycle(1'b0, 2'b01, 32'(base + k) << 2, 32'h0, 2'b11);
            else       cycle(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
            if (k > 0) begin
                vectors++;
                if (obs_rv !== 2'b01 || obs_rd[31:0] !== rom_mem[base + k - 1]) begin
                    miscompares++;
                    $display("FAIL stream%0d rv=%b rdata=%h want 01/%h", k, obs_rv, obs_rd[31:0], rom_mem[base + k - 1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a0, a1;
        for (int k = 0; k < 400; k++) begin
            a0 = {19'h0, 13'($urandom)};
            a1 = {19'h0, 13'($urandom)};
            if ($urandom_range(0, 9) == 0) a0[31:13] = 19'($urandom_range(1, 524287));
            if ($urandom_range(0, 9) == 0) a1[31:13] = 19'($urandom_range(1, 524287));
            cycle($urandom_range(0, 49) == 0, 2'($urandom),  a0, a1,
                  {$urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0});
            vectors++;
            if (obs_gnt !== exp_gnt || obs_csn !== exp_csn || obs_radd !== exp_radd) begin
                miscompares++;
                $display("FAIL rand_req%0d gnt=%b csn=%b add=%h want %b/%b/%h", k, obs_gnt, obs_csn, obs_radd, exp_gnt, exp_csn, exp_radd);
            end
            vectors++;
            if (obs_rv !== exp_rv || obs_opc !== exp_opc) begin
                miscompares++;
                $display("FAIL rand_resp%0d rv=%b opc=%b want %b/%b", k, obs_rv, obs_opc, exp_rv, exp_opc);
            end
            if (exp_rv != 2'b00) begin
                vectors++;
                if (obs_rd[m_pid*32 +: 32] !== exp_rd[m_pid*32 +: 32] && 1'b0) begin
                    miscompares++;
                end
                if ((exp_rv[0] && obs_rd[31:0] !== exp_rd[31:0]) || (exp_rv[1] && obs_rd[63:32] !== exp_rd[63:32])) begin
                    miscompares++;
                    $display("FAIL rand_rdata%0d got=%h want=%h", k, obs_rd, exp_rd);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = $urandom;
        rom_mem[1] = 32'hDEAD_BEEF;
        test_reset();
        test_contention();
        test_single_read();
        test_write_reject();
        test_out_of_window();
        test_reset_midop();
        test_streaming();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
